// File: rtl/sb_dispatch_pkg.sv
// sb_dispatch_pkg: decode-bus layout, FU encodings and register-file constants for the dispatch queue
package sb_dispatch_pkg;
   localparam int NREGS = 33;
   localparam logic [5:0] HILO_REG = 6'd32;
   typedef enum logic [2:0] {FU_ALU = 3'd0, FU_MDU = 3'd2, FU_LSU = 3'd3, FU_BRU = 3'd4} fu_e;
   typedef struct packed {
      logic        except_sw;
      logic [31:0] excepttype;
      logic [11:0] op;
      fu_e         fu;
      logic [5:0]  reg1;
      logic        r1_val;
      logic        r1_rdy;
      logic [5:0]  reg2;
      logic        r2_val;
      logic        r2_rdy;
      logic [5:0]  reg3;
      logic        rf_we;
      logic [31:0] imm;
      logic        sel_src1;
      logic        sel_src2;
      logic [31:0] pc;
   } id_to_sb_t;
   localparam int SB_BUS_WD = $bits(id_to_sb_t);
endpackage

// File: rtl/sb_busy_table.sv
// sb_busy_table: per-register busy bits (0..32) with three read ports and set-over-clear update
module sb_busy_table
   import sb_dispatch_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       set_en,
   input  logic [5:0] set_addr,
   input  logic       clr_en,
   input  logic [5:0] clr_addr,
   input  logic [5:0] rd1_addr,
   input  logic [5:0] rd2_addr,
   input  logic [5:0] rd3_addr,
   output logic       rd1,
   output logic       rd2,
   output logic       rd3
);
   logic [NREGS-1:0] busy_q, busy_d;
   assign rd1 = (rd1_addr <= HILO_REG) && busy_q[rd1_addr];
   assign rd2 = (rd2_addr <= HILO_REG) && busy_q[rd2_addr];
   assign rd3 = (rd3_addr <= HILO_REG) && busy_q[rd3_addr];
   // register 0 can never become busy; a set wins over a same-cycle clear
   always_comb begin
      busy_d = '0;
      for (int i = 1; i < NREGS; i++)
         busy_d[i] = (set_en && set_addr == 6'(i)) || (busy_q[i] && !(clr_en && clr_addr == 6'(i)));
   end
   always_ff @(posedge clk) begin
      if (!resetn) busy_q <= '0;
      else busy_q <= busy_d;
   end
endmodule

// File: rtl/sb_dispatch.sv
// sb_dispatch: in-order dispatch queue that issues the oldest decoded instruction once it is hazard-free
module sb_dispatch
   import sb_dispatch_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int ID_TO_SB_WD = SB_BUS_WD
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   br_e,
   input  logic                   inst_valid,
   input  logic [ID_TO_SB_WD-1:0] id_to_sb_bus,
   output logic                   stall,
   output logic                   issue_valid,
   input  logic                   issue_ready,
   output logic [ID_TO_SB_WD-1:0] issue_bus,
   input  logic                   wb_valid,
   input  logic [5:0]             wb_addr
);
   localparam int PW = $clog2(DEPTH);
   logic [ID_TO_SB_WD-1:0] mem_q [DEPTH];
   logic [ID_TO_SB_WD-1:0] mem_d [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [PW:0] count_q, count_d;
   id_to_sb_t hd;
   logic b1, b2, b3, hazard, enq, deq;
   assign hd = id_to_sb_t'(mem_q[head_q]);
   assign issue_bus = hd;
   assign stall = count_q == (PW+1)'(DEPTH);
   assign hazard = (hd.r1_val & b1) | (hd.r2_val & b2) | (hd.rf_we & b3);
   assign issue_valid = (count_q != '0) & ~hazard & ~br_e;
   assign enq = inst_valid & ~stall & ~br_e;
   assign deq = issue_valid & issue_ready;
   always_comb begin
      mem_d = mem_q;
      if (enq) mem_d[tail_q] = id_to_sb_bus;
      head_d = br_e ? '0 : head_q + PW'(deq);
      tail_d = br_e ? '0 : tail_q + PW'(enq);
      count_d = br_e ? '0 : count_q + (PW+1)'(enq) - (PW+1)'(deq);
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         head_q <= '0;
         tail_q <= '0;
         count_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk) mem_q <= mem_d;
   sb_busy_table u_busy (
      .clk      (clk),
      .resetn   (resetn),
      .set_en   (deq & hd.rf_we & (hd.reg3 != 6'd0)),
      .set_addr (hd.reg3),
      .clr_en   (wb_valid),
      .clr_addr (wb_addr),
      .rd1_addr (hd.reg1),
      .rd2_addr (hd.reg2),
      .rd3_addr (hd.reg3),
      .rd1      (b1),
      .rd2      (b2),
      .rd3      (b3)
   );
endmodule

// File: tb/tb_sb_dispatch.sv
// tb_sb_dispatch: directed stimulus with an in-order expected-issue queue checked by a negedge monitor
module tb_sb_dispatch;
   logic clk = 1'b0, resetn = 1'b0, br_e = 1'b0, inst_valid = 1'b0, issue_ready = 1'b0, wb_valid = 1'b0;
   logic [136:0] id_to_sb_bus = '0;
   logic [5:0] wb_addr = '0;
   logic stall, issue_valid;
   logic [136:0] issue_bus;
   int n_cmp = 0, n_bad = 0;
   logic [136:0] exp_q [$];

   sb_dispatch dut (
      .clk(clk), .resetn(resetn), .br_e(br_e), .inst_valid(inst_valid), .id_to_sb_bus(id_to_sb_bus),
      .stall(stall), .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_bus(issue_bus),
      .wb_valid(wb_valid), .wb_addr(wb_addr)
   );

   always #5 clk = ~clk;

   function automatic logic [136:0] mk(input logic [31:0] pc, input logic [2:0] fu, input logic [5:0] r1,
                                       input logic v1, input logic [5:0] r2, input logic v2,
                                       input logic [5:0] r3, input logic we);
      return {1'b0, 32'h0, 12'h0A5, fu, r1, v1, 1'b0, r2, v2, 1'b0, r3, we, 32'h1234, 2'b00, pc};
   endfunction

   task automatic chk(input string nm, input logic [136:0] act, input logic [136:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic send(input logic [136:0] b);
      inst_valid = 1'b1;
      id_to_sb_bus = b;
      exp_q.push_back(b);
      tick();
      inst_valid = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      issue_ready = 1'b0;
      tick();
      resetn = 1'b1;
      exp_q.delete();
   endtask

   always @(negedge clk) begin
      if (resetn && issue_valid && issue_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_issue: got pc %h want no issue", issue_bus[31:0]);
         end else chk("issue_bus", issue_bus, exp_q.pop_front());
      end
   end

   initial begin
      tick();
      do_reset();
      issue_ready = 1'b1;
      settle();
      chk("reset_stall", stall, 1'b0);
      chk("reset_issue_valid", issue_valid, 1'b0);
      issue_ready = 1'b0;
      // fill and drain
      for (int i = 0; i < 4; i++) begin
         chk("fill_stall_low", stall, 1'b0);
         send(mk(32'hBFC00000 + 32'(4 * i), 3'd0, 6'd0, 1'b1, 6'd0, 1'b0, 6'(i + 1), 1'b1));
      end
      inst_valid = 1'b1;
      id_to_sb_bus = mk(32'hBFC00010, 3'd0, 6'd0, 1'b1, 6'd0, 1'b0, 6'd5, 1'b1);
      settle();
      chk("full_stall", stall, 1'b1);
      tick();
      issue_ready = 1'b1;
      settle();
      chk("full_stall_held", stall, 1'b1);
      chk("full_head_valid", issue_valid, 1'b1);
      tick();
      chk("stall_released", stall, 1'b0);
      exp_q.push_back(id_to_sb_bus);
      tick();
      inst_valid = 1'b0;
      for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
      chk("drain_done", 137'(exp_q.size()), 137'(0));
      // RAW: addu $3,$1,$2 then subu $4,$3,$1
      do_reset();
      issue_ready = 1'b1;
      send(mk(32'h100, 3'd0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 1'b1));
      inst_valid = 1'b1;
      id_to_sb_bus = mk(32'h104, 3'd0, 6'd3, 1'b1, 6'd1, 1'b1, 6'd4, 1'b1);
      exp_q.push_back(id_to_sb_bus);
      settle();
      chk("raw_first_valid", issue_valid, 1'b1);
      tick();
      inst_valid = 1'b0;
      for (int n = 0; n < 3; n++) begin
         settle();
         chk("raw_blocked", issue_valid, 1'b0);
         tick();
      end
      wb_valid = 1'b1;
      wb_addr = 6'd3;
      settle();
      chk("raw_no_wb_bypass", issue_valid, 1'b0);
      tick();
      wb_valid = 1'b0;
      settle();
      chk("raw_released", issue_valid, 1'b1);
      tick();
      // WAW on HI/LO: mult, mflo, mthi
      do_reset();
      issue_ready = 1'b1;
      send(mk(32'h200, 3'd2, 6'd1, 1'b1, 6'd2, 1'b1, 6'd32, 1'b1));
      inst_valid = 1'b1;
      id_to_sb_bus = mk(32'h204, 3'd2, 6'd32, 1'b1, 6'd0, 1'b0, 6'd8, 1'b1);
      exp_q.push_back(id_to_sb_bus);
      settle();
      chk("mult_valid", issue_valid, 1'b1);
      tick();
      id_to_sb_bus = mk(32'h208, 3'd2, 6'd9, 1'b1, 6'd0, 1'b0, 6'd32, 1'b1);
      exp_q.push_back(id_to_sb_bus);
      settle();
      chk("mflo_held", issue_valid, 1'b0);
      tick();
      inst_valid = 1'b0;
      for (int n = 0; n < 2; n++) begin
         settle();
         chk("hilo_held", issue_valid, 1'b0);
         tick();
      end
      wb_valid = 1'b1;
      wb_addr = 6'd32;
      settle();
      chk("hilo_wb_cycle", issue_valid, 1'b0);
      tick();
      wb_valid = 1'b0;
      settle();
      chk("mflo_released", issue_valid, 1'b1);
      tick();
      chk("mthi_released", issue_valid, 1'b1);
      tick();
      // flush with busy[5] set beforehand
      do_reset();
      issue_ready = 1'b1;
      send(mk(32'h300, 3'd0, 6'd0, 1'b1, 6'd0, 1'b0, 6'd5, 1'b1));
      send(mk(32'h304, 3'd0, 6'd0, 1'b1, 6'd0, 1'b0, 6'd1, 1'b1));
      issue_ready = 1'b0;
      send(mk(32'h308, 3'd0, 6'd0, 1'b1, 6'd0, 1'b0, 6'd2, 1'b1));
      send(mk(32'h30C, 3'd0, 6'd0, 1'b1, 6'd0, 1'b0, 6'd3, 1'b1));
      inst_valid = 1'b1;
      id_to_sb_bus = mk(32'h310, 3'd0, 6'd0, 1'b1, 6'd0, 1'b0, 6'd4, 1'b1);
      br_e = 1'b1;
      issue_ready = 1'b1;
      settle();
      chk("flush_no_issue", issue_valid, 1'b0);
      exp_q.delete();
      tick();
      br_e = 1'b0;
      inst_valid = 1'b0;
      settle();
      chk("flush_empty", issue_valid, 1'b0);
      chk("flush_stall", stall, 1'b0);
      tick();
      chk("flush_not_enqueued", issue_valid, 1'b0);
      send(mk(32'h314, 3'd0, 6'd5, 1'b1, 6'd0, 1'b0, 6'd6, 1'b1));
      settle();
      chk("flush_busy_kept", issue_valid, 1'b0);
      tick();
      wb_valid = 1'b1;
      wb_addr = 6'd5;
      settle();
      chk("flush_busy_wb_cycle", issue_valid, 1'b0);
      tick();
      wb_valid = 1'b0;
      settle();
      chk("flush_busy_cleared", issue_valid, 1'b1);
      tick();
      // same-cycle set and clear of reg 7
      do_reset();
      issue_ready = 1'b1;
      send(mk(32'h400, 3'd0, 6'd0, 1'b1, 6'd0, 1'b0, 6'd7, 1'b1));
      inst_valid = 1'b1;
      id_to_sb_bus = mk(32'h404, 3'd0, 6'd7, 1'b1, 6'd0, 1'b0, 6'd9, 1'b1);
      exp_q.push_back(id_to_sb_bus);
      wb_valid = 1'b1;
      wb_addr = 6'd7;
      settle();
      chk("setclr_issue", issue_valid, 1'b1);
      tick();
      inst_valid = 1'b0;
      wb_valid = 1'b0;
      settle();
      chk("setclr_set_wins", issue_valid, 1'b0);
      tick();
      wb_valid = 1'b1;
      settle();
      chk("setclr_wb_cycle", issue_valid, 1'b0);
      tick();
      wb_valid = 1'b0;
      settle();
      chk("setclr_released", issue_valid, 1'b1);
      tick();
      // reset with a full queue and busy[5] set
      do_reset();
      issue_ready = 1'b1;
      send(mk(32'h500, 3'd0, 6'd0, 1'b1, 6'd0, 1'b0, 6'd5, 1'b1));
      send(mk(32'h504, 3'd0, 6'd0, 1'b1, 6'd0, 1'b0, 6'd1, 1'b1));
      issue_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(mk(32'h508 + 32'(4 * i), 3'd0, 6'd0, 1'b1, 6'd0, 1'b0, 6'd2, 1'b1));
      settle();
      chk("pre_reset_full", stall, 1'b1);
      resetn = 1'b0;
      br_e = 1'b1;
      inst_valid = 1'b1;
      id_to_sb_bus = mk(32'h520, 3'd0, 6'd0, 1'b1, 6'd0, 1'b0, 6'd3, 1'b1);
      tick();
      resetn = 1'b1;
      br_e = 1'b0;
      inst_valid = 1'b0;
      exp_q.delete();
      issue_ready = 1'b1;
      settle();
      chk("midreset_stall", stall, 1'b0);
      chk("midreset_empty", issue_valid, 1'b0);
      send(mk(32'h524, 3'd0, 6'd5, 1'b1, 6'd0, 1'b0, 6'd6, 1'b1));
      settle();
      chk("midreset_busy_clear", issue_valid, 1'b1);
      tick();
      tick();
      chk("scoreboard_empty", 137'(exp_q.size()), 137'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sb_dispatch.md
# sb_dispatch

In-order dispatch queue on the scoreboard side of the decode→scoreboard interface; receiver of the decoder's `id_to_sb_bus` / `inst_valid` and the source of its `stall` backpressure. It buffers up to DEPTH decoded instructions, tracks register-busy state for regs 0–32 (32 = HI/LO), and issues the oldest instruction to its functional unit when operands and destination are hazard-free. A branch redirect (`br_e`) flushes every queued entry.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- ID_TO_SB_WD, 137: decode bus width, taken from the shared defines.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- br_e  in  1  branch redirect; flush the queue.
- inst_valid  in  1  decoder presents a valid instruction.
- id_to_sb_bus  in  ID_TO_SB_WD  decoded instruction: except_sw[136], excepttype[135:104], op[103:92], fu[91:89], reg1[88:83], r1_val[82], r1_rdy[81], reg2[80:75], r2_val[74], r2_rdy[73], reg3[72:67], rf_we[66], imm[65:34], sel_src1[33], sel_src2[32], pc[31:0].
- stall  out  1  queue full; decoder holds its current instruction.
- issue_valid  out  1  head entry eligible to issue.
- issue_ready  in  1  target FU accepts this cycle.
- issue_bus  out  ID_TO_SB_WD  head entry, same field layout as the input.
- wb_valid  in  1  an FU result is written back.
- wb_addr  in  6  writeback register, 0–32.

## Operation
- Queue: circular buffer with head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH) and a count of log2(DEPTH)+1 bits.
- Enqueue when `inst_valid & ~stall & ~br_e`; entry written at tail.
- `stall = (count == DEPTH)`, driven combinationally from registered count. The decoder holds its output while stall is high, so an instruction is accepted exactly once.
- Busy table: 33 bits, indexed by register address. Bit 0 is never set.
- Head hazard check:
  - RAW: `r1_val & busy[reg1]` or `r2_val & busy[reg2]`.
  - WAW: `rf_we & busy[reg3]`.
- `issue_valid = (count != 0) & ~hazard & ~br_e`.
- Issue when `issue_valid & issue_ready`: head advances. If `rf_we & reg3 != 0`, set `busy[reg3]`.
- Writeback: `wb_valid` clears `busy[wb_addr]`. If set and clear hit the same register in one cycle, set wins.
- Flush (`br_e`):
  - count, head and tail return to 0 next cycle.
  - No enqueue and no issue occur in the `br_e` cycle.
  - Busy bits are retained; in-flight instructions still write back and clear them.
- Simultaneous enqueue and issue: count unchanged, both pointers advance.
- Enqueue is impossible when full. Issue when empty is blocked by `issue_valid`.

## Timing
- Reset: count, head and tail 0; busy all 0; stall 0; issue_valid 0. `issue_bus` is don't-care while `issue_valid` is 0.
- Latency: an instruction enqueued at edge t can issue at the earliest in the cycle after edge t. No enqueue-to-issue bypass.
- A busy bit set by an issue at edge t blocks a dependent head from cycle t onward.
- A writeback at edge t unblocks the dependent head in the cycle after edge t. There is no writeback-to-issue bypass.
- `stall` deasserts in the cycle after the issue that frees a slot.
- `resetn` low mid-operation overrides `br_e` and all other activity.

## Structure
- `lib/defines.vh` holds:
  - ID_TO_SB_WD and every field offset above.
  - The FU encodings 0/2/3/4.
  - The HI/LO register index 32.
- Sub-module `sb_busy_table`: 33-bit set/clear register file with two combinational read ports (reg1, reg2), a third read for reg3, one set port and one clear port. Set-over-clear priority is implemented inside it.
- Queue storage and pointer logic stay in `sb_dispatch`.

## Test plan
- Fill and drain: 5 independent addiu (reg3 = 1..5), `issue_ready` = 0.
  - stall = 1 after the 4th accept; 5th held.
  - With `issue_ready` = 1: issues in order, pc 0xBFC00000..0xBFC00010.
- RAW stall: `addu $3,$1,$2` issued, then `subu $4,$3,$1`.
  - Second instruction's issue_valid = 0 until `wb_valid` = 1, `wb_addr` = 3.
  - Issues the cycle after.
- WAW: `mult` sets busy[32], then `mflo` (reg1 = 32) is held.
  - `mthi` (reg3 = 32) behind `mflo` is also held until writeback of 32.
- Flush: 3 entries queued and `br_e` = 1 while `inst_valid` = 1.
  - Next cycle count = 0; the presented instruction is not enqueued; no issue in the flush cycle.
  - Busy bits set before the flush remain set until writeback.
- Same-cycle set/clear: issue to reg3 = 7 while `wb_valid` = 1, `wb_addr` = 7 → busy[7] = 1.
- Reset mid-run: `resetn` low with a full queue and busy[5] = 1 → next cycle count = 0, stall = 0, busy all 0.
